// File: rtl/parity_pkg.sv
// Shared parity definitions for the checker and the upstream generator.
// Holds the checker state type, byte count and per-byte parity helper.
package parity_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

   localparam int DW_DEF = 32;
   localparam int BYTES  = DW_DEF / 8;

   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational per-byte even-parity generator.
// Bit i of exp_o covers din_i[8i+7:8i].
module parity_calc
   import parity_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0]   din_i,
   output logic [DW/8-1:0] exp_o
);

   // one parity bit per byte lane
   always_comb begin
      exp_o = '0;
      for (int i = 0; i < DW / 8; i++) begin
         exp_o[i] = byte_parity(din_i[8*i +: 8]);
      end
   end

endmodule

// File: rtl/parity_check.sv
// Registered parity checker with error counters and halt-on-burst.
// Clear pulse zeroes counters and resumes from HALT.
module parity_check
   import parity_pkg::*;
#(
   parameter int DW        = 32,
   parameter int ERR_LIMIT = 3,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     din,
   input  logic [DW/8-1:0]   parity,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     dout,
   output logic [DW/8-1:0]   err_byte,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              err_sticky,
   output logic              halted,
   input  logic              clr_err
);

   localparam int NB = DW / 8;
   localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_q;
   logic              out_valid_q, out_valid_d;
   logic [DW-1:0]     dout_q, dout_d;
   logic [NB-1:0]     err_byte_q, err_byte_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              sticky_q, sticky_d;
   logic [3:0]        consec_q, consec_d;
   logic [NB-1:0]     exp_par;
   logic [NB-1:0]     err;
   logic              accept;
   logic              bad;

   parity_calc #(.DW(DW)) u_calc (
      .din_i (din),
      .exp_o (exp_par)
   );

   assign err      = exp_par ^ parity;
   assign bad      = |err;
   assign in_ready = rst_n && (state_q == RUN)
                     && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // next-state for output register and counters; clear overrides
   always_comb begin
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      err_byte_d  = err_byte_q;
      err_cnt_d   = err_cnt_q;
      sticky_d    = sticky_q;
      consec_d    = consec_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         out_valid_d = 1'b1;
         dout_d      = din;
         err_byte_d  = err;
         if (bad) begin
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + ONE;
            end
            sticky_d = 1'b1;
            if (consec_q != 4'hF) begin
               consec_d = consec_q + 4'd1;
            end
         end else begin
            consec_d = '0;
         end
      end
      if (clr_err) begin
         err_cnt_d = '0;
         sticky_d  = 1'b0;
         consec_d  = '0;
      end
   end

   // data path and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         err_byte_q  <= '0;
         err_cnt_q   <= '0;
         sticky_q    <= 1'b0;
         consec_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         err_byte_q  <= err_byte_d;
         err_cnt_q   <= err_cnt_d;
         sticky_q    <= sticky_d;
         consec_q    <= consec_d;
      end
   end

   // RUN/HALT control: halt on error burst, resume on clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (accept && bad && (consec_d == LIMIT)) begin
                  state_q <= HALT;
               end
            end
            HALT: begin
               if (clr_err) begin
                  state_q <= RUN;
               end
            end
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign dout       = dout_q;
   assign err_byte   = err_byte_q;
   assign err_cnt    = err_cnt_q;
   assign err_sticky = sticky_q;
   assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_parity_check.sv
// Directed bench for parity_check with default parameters.
// Expected values are hand-computed per-byte even parity.
module tb_parity_check;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] din;
   logic [3:0]  parity;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] dout;
   logic [3:0]  err_byte;
   logic [15:0] err_cnt;
   logic        err_sticky;
   logic        halted;
   logic        clr_err;

   int passed = 0;
   int total  = 0;

   parity_check #(.DW(32), .ERR_LIMIT(3), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .din        (din),
      .parity     (parity),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .dout       (dout),
      .err_byte   (err_byte),
      .err_cnt    (err_cnt),
      .err_sticky (err_sticky),
      .halted     (halted),
      .clr_err    (clr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; din = '0; parity = '0;
      out_ready = 1'b1; clr_err = 1'b0;
      tick(); tick();
      total++;
      if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready);
      else passed++;
      total++;
      if ({out_valid, dout, err_byte} !== 37'd0)
         $display("FAIL rst_out got %b %h %b want 0", out_valid, dout, err_byte);
      else passed++;
      total++;
      if ({err_cnt, err_sticky, halted} !== 18'd0)
         $display("FAIL rst_err got %0d %b %b want 0", err_cnt, err_sticky, halted);
      else passed++;
      rst_n = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready);
      else passed++;
   endtask

   task automatic test_clean();
      in_valid = 1'b1; din = 32'h01020304; parity = 4'b1101;
      tick();
      in_valid = 1'b0;
      total++;
      if ({out_valid, dout, err_byte, err_cnt} !== {1'b1, 32'h01020304, 4'b0, 16'd0})
         $display("FAIL clean got v=%b d=%h e=%b c=%0d want 1 01020304 0000 0",
                  out_valid, dout, err_byte, err_cnt);
      else passed++;
      tick();
      total++;
      if (out_valid !== 1'b0) $display("FAIL clean_drain got %b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_corrupt();
      in_valid = 1'b1; din = 32'h01020304; parity = 4'b1100;
      tick();
      in_valid = 1'b0;
      total++;
      if ({err_byte, err_cnt, err_sticky} !== {4'b0001, 16'd1, 1'b1})
         $display("FAIL corrupt got e=%b c=%0d s=%b want 0001 1 1",
                  err_byte, err_cnt, err_sticky);
      else passed++;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      total++;
      if ({err_cnt, err_sticky, halted} !== 18'd0)
         $display("FAIL corrupt_clr got c=%0d s=%b h=%b want 0 0 0",
                  err_cnt, err_sticky, halted);
      else passed++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; din = 32'h11223344; parity = 4'b0000;
      tick();
      din = 32'h00000107; parity = 4'b0011;
      total++;
      if (in_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", in_ready);
      else passed++;
      tick(); tick();
      total++;
      if ({out_valid, dout} !== {1'b1, 32'h11223344})
         $display("FAIL bp_hold got v=%b d=%h want 1 11223344", out_valid, dout);
      else passed++;
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL bp_resume_ready got %b want 1", in_ready);
      else passed++;
      tick();
      in_valid = 1'b0;
      total++;
      if ({out_valid, dout, err_byte} !== {1'b1, 32'h00000107, 4'b0000})
         $display("FAIL bp_second got v=%b d=%h e=%b want 1 00000107 0000",
                  out_valid, dout, err_byte);
      else passed++;
      tick();
      total++;
      if ({out_valid, err_cnt} !== {1'b0, 16'd0})
         $display("FAIL bp_drain got v=%b c=%0d want 0 0", out_valid, err_cnt);
      else passed++;
   endtask

   task automatic test_halt();
      out_ready = 1'b1;
      in_valid = 1'b1; din = 32'h01020304; parity = 4'b1100;
      tick(); tick();
      total++;
      if (halted !== 1'b0) $display("FAIL halt_early got %b want 0", halted);
      else passed++;
      tick();
      total++;
      if ({halted, in_ready, err_cnt} !== {1'b1, 1'b0, 16'd3})
         $display("FAIL halt got h=%b r=%b c=%0d want 1 0 3", halted, in_ready, err_cnt);
      else passed++;
      in_valid = 1'b0;
      tick();
      total++;
      if ({out_valid, halted} !== 2'b01)
         $display("FAIL halt_drain got v=%b h=%b want 0 1", out_valid, halted);
      else passed++;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      total++;
      if ({err_cnt, halted, in_ready} !== {16'd0, 1'b0, 1'b1})
         $display("FAIL halt_clr got c=%0d h=%b r=%b want 0 0 1", err_cnt, halted, in_ready);
      else passed++;
   endtask

   task automatic test_no_halt();
      logic [3:0] pv [4];
      pv[0] = 4'b1100; pv[1] = 4'b1101; pv[2] = 4'b1100; pv[3] = 4'b1100;
      out_ready = 1'b1; din = 32'h01020304; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         parity = pv[i];
         tick();
      end
      in_valid = 1'b0;
      total++;
      if ({halted, err_cnt} !== {1'b0, 16'd3})
         $display("FAIL nohalt got h=%b c=%0d want 0 3", halted, err_cnt);
      else passed++;
      in_valid = 1'b1; parity = 4'b0101; clr_err = 1'b1;
      tick();
      in_valid = 1'b0; clr_err = 1'b0;
      total++;
      if ({err_cnt, err_sticky, err_byte, halted} !== {16'd0, 1'b0, 4'b1000, 1'b0})
         $display("FAIL clr_wins got c=%0d s=%b e=%b h=%b want 0 0 1000 0",
                  err_cnt, err_sticky, err_byte, halted);
      else passed++;
      tick();
   endtask

   task automatic test_reset_halted();
      out_ready = 1'b1;
      in_valid = 1'b1; din = 32'h01020304; parity = 4'b1100;
      tick(); tick(); tick();
      in_valid = 1'b0; out_ready = 1'b0;
      total++;
      if ({halted, out_valid} !== 2'b11)
         $display("FAIL pre_rst got h=%b v=%b want 1 1", halted, out_valid);
      else passed++;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++;
      if ({out_valid, dout, err_byte, err_cnt, err_sticky, halted} !== 55'd0)
         $display("FAIL rst_halted got v=%b d=%h e=%b c=%0d s=%b h=%b want all 0",
                  out_valid, dout, err_byte, err_cnt, err_sticky, halted);
      else passed++;
      tick();
      total++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL rst_resume got r=%b v=%b want 1 0", in_ready, out_valid);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_corrupt();
      test_backpressure();
      test_halt();
      test_no_halt();
      test_reset_halted();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/parity_check.md
PARITY_CHECK -- requirements
Module: parity_check

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width in bits; a multiple of 8.
REQ-002 The block SHALL have parameter ERR_LIMIT, default 3, meaning the number of consecutive erroneous words that forces HALT (range 1..15).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the error counter width.
REQ-004 The block SHALL have ports as follows; one clock, and reset is synchronous and active-low:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block accepts the word this cycle.
- din  input  DW  data word from the parity generator.
- parity  input  DW/8  per-byte parity; bit i covers din[8i+7:8i].
- out_valid  output  1  registered word available.
- out_ready  input  1  downstream accepts the word.
- dout  output  DW  registered copy of the accepted din.
- err_byte  output  DW/8  per-byte mismatch flags for the word on dout.
- err_cnt  output  CNT_W  total erroneous words, saturating.
- err_sticky  output  1  at least one error since reset or clear.
- halted  output  1  high while in HALT.
- clr_err  input  1  single-cycle clear and resume pulse.

Function
REQ-005 The expected parity SHALL be even, per byte: exp[i] = XOR of din[8i+7:8i]; err[i] = exp[i] XOR parity[i].
REQ-006 A word SHALL be accepted on any cycle where in_valid && in_ready.
REQ-007 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready), so the output register is never overwritten while it holds undrained data.
REQ-008 On accept, dout<=din, err_byte<=err and out_valid<=1 on the next edge, giving a latency of 1 cycle.
REQ-009 If out_valid && out_ready and there is no accept, out_valid SHALL go to 0; if both occur, out_valid SHALL stay 1 with the new data.
REQ-010 dout and err_byte SHALL hold their value while out_valid && !out_ready.
REQ-011 An accepted word with err!=0 SHALL increment err_cnt, which saturates at all-ones, and SHALL set err_sticky.
REQ-012 An internal consecutive-error counter SHALL increment on an erroneous accept and clear on a clean accept; non-accept cycles leave it unchanged.
REQ-013 The state machine SHALL have two states, RUN and HALT: RUN->HALT on the edge where the consecutive count reaches ERR_LIMIT; HALT->RUN on the edge after clr_err=1.
REQ-014 In HALT, in_ready SHALL be 0, while the output register still drains normally.
REQ-015 clr_err SHALL clear err_cnt, err_sticky and the consecutive counter in either state.
REQ-016 If clr_err coincides with an erroneous accept, the clear SHALL win (counters end at 0, err_sticky at 0), but err_byte still reflects the word.
REQ-017 halted SHALL be 1 exactly when state==HALT.

Reset
REQ-018 On rst_n==0 at a clk edge: state=RUN, out_valid=0, dout=0, err_byte=0, err_cnt=0, err_sticky=0, consecutive counter=0.
REQ-019 A reset during HALT or with undrained output SHALL discard the held word, with no output handshake.
REQ-020 in_ready SHALL be 0 while rst_n==0.

Structure
REQ-021 Package parity_pkg SHALL hold the state enum (RUN, HALT), the BYTES=DW/8 helper constant and a byte_parity function, shared with the upstream generator.
REQ-022 One sub-module, parity_calc, SHALL be combinational and map din to exp[DW/8-1:0]; the checker instantiates it.

Verification
REQ-023 Clean word: din=32'h01020304, parity=4'b1101, out_ready=1 -> next cycle out_valid=1, dout=32'h01020304, err_byte=0, err_cnt=0.
REQ-024 Corrupt byte 0: din=32'h01020304, parity=4'b1100 -> err_byte=4'b0001, err_cnt=1, err_sticky=1.
REQ-025 Backpressure: out_ready=0 with two valid words offered -> in_ready=0 after the first, dout holds the first; out_ready=1 -> second accepted, no loss or duplication.
REQ-026 Three consecutive corrupt words (ERR_LIMIT=3) -> halted=1 after the third, in_ready=0, err_cnt=3; clr_err pulse -> err_cnt=0, halted=0 next cycle.
REQ-027 Corrupt, clean, corrupt, corrupt -> no HALT, err_cnt=3; clr_err together with a corrupt accept -> err_cnt=0, err_byte nonzero.
REQ-028 rst_n=0 for one cycle while halted with out_valid=1 -> all outputs at reset values, in_ready=1 after reset is released.
